// File: rtl/spi_reg_master_if.sv
// Request/response bus of the SPI register master. The requester drives the
// master modport and the SPI engine sits on the slave modport.
interface spi_reg_master_if #(
  parameter int AW = 16,
  parameter int DW = 32
) ();
  logic          req_valid;
  logic          req_ready;
  logic          req_wr;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          busy;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, busy
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, busy
  );
endinterface

// File: rtl/spi_reg_master.sv
// SPI mode-0 initiator issuing one register write or read per request:
// frame = opcode(8) | address(AW) | data(DW), MSB first, SCK from a clk divider.
module spi_reg_master #(
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 4,
  parameter int AW      = 16,
  parameter int DW      = 32
) (
  input  logic             clk,
  input  logic             rstn,
  spi_reg_master_if.slave  bus,
  output logic             spi_sck,
  output logic             spi_ss_n,
  output logic             spi_mosi,
  input  logic             spi_miso
);

  localparam int N       = 8 + AW + DW;
  localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int BW      = $clog2(N);

  localparam logic [7:0] OP_WR = 8'h02;
  localparam logic [7:0] OP_RD = 8'h03;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] div_q, div_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [N-2:0]  tx_q, tx_d;
  logic [DW-1:0] rx_q, rx_d;
  logic          wr_q, wr_d;

  logic          sck_q, sck_d;
  logic          ss_n_q, ss_n_d;
  logic          mosi_q, mosi_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;

  logic          accept;
  logic          phase_end;
  logic          gap_end;
  logic          last_bit;
  logic          sample_miso;
  logic [N-1:0]  frame_w;

  assign accept      = bus.req_valid && ready_q;
  assign phase_end   = (div_q == CW'(CLK_DIV - 1));
  assign gap_end     = (div_q == CW'(CS_GAP - 1));
  assign last_bit    = (bit_q == BW'(N - 1));
  // Only the data-field bits of the frame land in the read register.
  assign sample_miso = (bit_q >= BW'(N - DW));
  assign frame_w     = {bus.req_wr ? OP_WR : OP_RD,
                        bus.req_addr,
                        bus.req_wr ? bus.req_wdata : {DW{1'b0}}};

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge regardless of order.
  // NOTE: the shift registers are reset as well so no X reaches the pins
  // or rsp_rdata after an aborted frame.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      wr_q        <= 1'b0;
      sck_q       <= 1'b0;
      ss_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      wr_q        <= wr_d;
      sck_q       <= sck_d;
      ss_n_q      <= ss_n_d;
      mosi_q      <= mosi_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

  // NOTE: every variable assigned in a combinational block gets a default
  // first; a path that skips an assignment would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    wr_d    = wr_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_SETUP;
          div_d   = '0;
          tx_d    = frame_w[N-2:0];
          wr_d    = bus.req_wr;
        end
      end
      S_SETUP: begin
        if (phase_end) begin
          // First rising SCK edge: bit 0 is never a data bit, nothing to sample.
          state_d = S_SHIFT;
          div_d   = '0;
        end else begin
          div_d = div_q + CW'(1);
        end
      end
      S_SHIFT: begin
        if (phase_end) begin
          div_d = '0;
          if (sck_q) begin
            if (last_bit) begin
              state_d = S_HOLD;
            end else begin
              bit_d = bit_q + BW'(1);
              tx_d  = {tx_q[N-3:0], 1'b0};
            end
          end else if (sample_miso) begin
            rx_d = {rx_q[DW-2:0], spi_miso};
          end
        end else begin
          div_d = div_q + CW'(1);
        end
      end
      S_HOLD: begin
        if (phase_end) begin
          state_d = S_GAP;
          div_d   = '0;
        end else begin
          div_d = div_q + CW'(1);
        end
      end
      S_GAP: begin
        if (gap_end) begin
          state_d = S_IDLE;
          div_d   = '0;
          bit_d   = '0;
        end else begin
          div_d = div_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        div_d   = '0;
        bit_d   = '0;
      end
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    sck_d       = sck_q;
    ss_n_d      = ss_n_q;
    mosi_d      = mosi_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    ready_d     = ready_q;
    busy_d      = busy_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          ready_d = 1'b0;
          busy_d  = 1'b1;
          ss_n_d  = 1'b0;
          mosi_d  = frame_w[N-1];
        end
      end
      S_SETUP: begin
        if (phase_end) sck_d = 1'b1;
      end
      S_SHIFT: begin
        if (phase_end) begin
          if (sck_q) begin
            sck_d  = 1'b0;
            mosi_d = last_bit ? 1'b0 : tx_q[N-2];
          end else begin
            sck_d = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (phase_end) begin
          ss_n_d      = 1'b1;
          rsp_valid_d = 1'b1;
          rdata_d     = wr_q ? '0 : rx_q;
        end
      end
      S_GAP: begin
        if (gap_end) begin
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        sck_d  = 1'b0;
        ss_n_d = 1'b1;
        mosi_d = 1'b0;
      end
    endcase
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.busy      = busy_q;
  assign spi_sck       = sck_q;
  assign spi_ss_n      = ss_n_q;
  assign spi_mosi      = mosi_q;

endmodule

// File: tb/tb_spi_reg_master.sv
// Directed bench for spi_reg_master: an SPI slave model decodes frames and
// serves read data; timing is checked against hand-computed cycle offsets.
module tb_spi_reg_master;

  localparam int AW     = 16;
  localparam int DW     = 32;
  localparam int N      = 8 + AW + DW;
  localparam int CS_GAP = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  spi_reg_master_if #(.AW(AW), .DW(DW)) bus0 ();
  spi_reg_master_if #(.AW(AW), .DW(DW)) bus1 ();

  logic sck0, ss0, mosi0;
  logic miso0 = 1'b0;
  logic sck1, ss1, mosi1;
  logic miso1 = 1'b0;

  spi_reg_master #(.CLK_DIV(2), .CS_GAP(CS_GAP), .AW(AW), .DW(DW)) dut0 (
    .clk      (clk),
    .rstn     (rstn),
    .bus      (bus0),
    .spi_sck  (sck0),
    .spi_ss_n (ss0),
    .spi_mosi (mosi0),
    .spi_miso (miso0)
  );

  spi_reg_master #(.CLK_DIV(5), .CS_GAP(CS_GAP), .AW(AW), .DW(DW)) dut1 (
    .clk      (clk),
    .rstn     (rstn),
    .bus      (bus1),
    .spi_sck  (sck1),
    .spi_ss_n (ss1),
    .spi_mosi (mosi1),
    .spi_miso (miso1)
  );

  int total = 0;
  int bad   = 0;

  // SPI slave model for dut0: captures mosi on rising SCK, drives miso after
  // falling SCK with the data bit for the next frame position.
  logic [N-1:0]  sl_frame = '0;
  logic [N-1:0]  sl_last  = '0;
  logic [DW-1:0] sl_rdata = '0;
  int            sl_rises = 0;
  int            sl_falls = 0;
  int            sl_last_rises = 0;

  always @(negedge ss0) begin
    sl_frame = '0;
    sl_rises = 0;
    sl_falls = 0;
    miso0    = 1'b0;
  end

  always @(posedge ss0) begin
    sl_last       = sl_frame;
    sl_last_rises = sl_rises;
  end

  always @(posedge sck0) begin
    if (!ss0) begin
      sl_frame = {sl_frame[N-2:0], mosi0};
      sl_rises++;
    end
  end

  always @(negedge sck0) begin
    int j;
    if (!ss0) begin
      j = sl_falls + 1;
      if (j >= N - DW && j < N) miso0 = sl_rdata[N-1-j];
      sl_falls++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // Starts a dut0 transaction at a negedge and follows it until req_ready rises.
  // Sample i is the negedge i cycles after the accept edge, i.e. offset T+i.
  task automatic run_txn(input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata,
                         output int rsp_at, output int ready_at,
                         output int rises, output int pulses,
                         output logic [DW-1:0] rdata);
    logic prev_sck;
    rsp_at   = 0;
    ready_at = 0;
    rises    = 0;
    pulses   = 0;
    rdata    = '0;
    bus0.req_valid = 1'b1;
    bus0.req_wr    = wr;
    bus0.req_addr  = addr;
    bus0.req_wdata = wdata;
    prev_sck = sck0;
    for (int i = 1; i <= 600; i++) begin
      @(negedge clk);
      if (i == 1) begin
        bus0.req_valid = 1'b0;
        total++;
        if (ss0 !== 1'b0 || bus0.req_ready !== 1'b0 || bus0.busy !== 1'b1) begin
          bad++;
          $display("FAIL accept: ss_n=%b ready=%b busy=%b expected 0 0 1",
                   ss0, bus0.req_ready, bus0.busy);
        end
      end
      if (sck0 === 1'b1 && prev_sck === 1'b0) rises++;
      prev_sck = sck0;
      if (bus0.rsp_valid === 1'b1) begin
        pulses++;
        if (rsp_at == 0) begin
          rsp_at = i;
          rdata  = bus0.rsp_rdata;
          total++;
          if (ss0 !== 1'b1) begin
            bad++;
            $display("FAIL ss_at_rsp: ss_n=%b expected 1", ss0);
          end
        end
      end
      if (bus0.req_ready === 1'b1) begin
        ready_at = i;
        break;
      end
    end
    total++;
    if (ready_at == 0) begin
      bad++;
      $display("FAIL txn_timeout: req_ready never returned high");
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    #1;
    total++;
    if (bus0.req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b expected 1", bus0.req_ready); end
    total++;
    if (ss0 !== 1'b1) begin bad++; $display("FAIL reset_ss_n: got %b expected 1", ss0); end
    total++;
    if (sck0 !== 1'b0) begin bad++; $display("FAIL reset_sck: got %b expected 0", sck0); end
    total++;
    if (bus0.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b expected 0", bus0.rsp_valid); end
    total++;
    if (bus0.busy !== 1'b0 || mosi0 !== 1'b0 || bus0.rsp_rdata !== '0) begin
      bad++;
      $display("FAIL reset_misc: busy=%b mosi=%b rdata=%h expected 0 0 0",
               bus0.busy, mosi0, bus0.rsp_rdata);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write();
    int rsp_at, ready_at, rises, pulses;
    logic [DW-1:0] rdata;
    run_txn(1'b1, 16'h0010, 32'hDEADBEEF, rsp_at, ready_at, rises, pulses, rdata);
    total++;
    if (sl_last[N-1 -: 8] !== 8'h02) begin bad++; $display("FAIL wr_opcode: got %h expected 02", sl_last[N-1 -: 8]); end
    total++;
    if (sl_last[DW +: AW] !== 16'h0010) begin bad++; $display("FAIL wr_addr: got %h expected 0010", sl_last[DW +: AW]); end
    total++;
    if (sl_last[DW-1:0] !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_data: got %h expected deadbeef", sl_last[DW-1:0]); end
    total++;
    if (rises != 56 || sl_last_rises != 56) begin bad++; $display("FAIL wr_rises: got %0d/%0d expected 56", rises, sl_last_rises); end
    total++;
    if (rsp_at != 227) begin bad++; $display("FAIL wr_rsp_time: got T+%0d expected T+227", rsp_at); end
    total++;
    if (rdata !== 32'h0) begin bad++; $display("FAIL wr_rdata: got %h expected 0", rdata); end
    total++;
    if (ready_at != 231) begin bad++; $display("FAIL wr_ready_time: got T+%0d expected T+231", ready_at); end
    total++;
    if (pulses != 1 || bus0.busy !== 1'b0) begin bad++; $display("FAIL wr_pulse_busy: pulses=%0d busy=%b expected 1 0", pulses, bus0.busy); end
  endtask

  task automatic test_read();
    int rsp_at, ready_at, rises, pulses;
    logic [DW-1:0] rdata;
    sl_rdata = 32'h12345678;
    run_txn(1'b0, 16'h0004, 32'hFFFFFFFF, rsp_at, ready_at, rises, pulses, rdata);
    total++;
    if (sl_last[N-1 -: 8] !== 8'h03) begin bad++; $display("FAIL rd_opcode: got %h expected 03", sl_last[N-1 -: 8]); end
    total++;
    if (sl_last[DW +: AW] !== 16'h0004) begin bad++; $display("FAIL rd_addr: got %h expected 0004", sl_last[DW +: AW]); end
    total++;
    if (sl_last[DW-1:0] !== 32'h0) begin bad++; $display("FAIL rd_mosi_data: got %h expected 0", sl_last[DW-1:0]); end
    total++;
    if (rdata !== 32'h12345678) begin bad++; $display("FAIL rd_rdata: got %h expected 12345678", rdata); end
    total++;
    if (pulses != 1 || rsp_at != 227) begin bad++; $display("FAIL rd_pulse: pulses=%0d at T+%0d expected 1 at T+227", pulses, rsp_at); end
    total++;
    if (bus0.rsp_rdata !== 32'h12345678) begin bad++; $display("FAIL rd_hold: got %h expected 12345678", bus0.rsp_rdata); end
  endtask

  task automatic test_back_to_back();
    int rsp1 = 0, rsp2 = 0, acc = 0, done = 0, gap_low = 0;
    logic [DW-1:0] rd1 = '1;
    logic [N-1:0]  frame_a = '0;
    bus0.req_valid = 1'b1;
    bus0.req_wr    = 1'b1;
    bus0.req_addr  = 16'h0020;
    bus0.req_wdata = 32'h01234567;
    for (int i = 1; i <= 1000; i++) begin
      @(negedge clk);
      if (i == 1) begin
        bus0.req_addr  = 16'h0024;
        bus0.req_wdata = 32'h89ABCDEF;
      end
      if (bus0.rsp_valid === 1'b1) begin
        if (rsp1 == 0) begin
          rsp1 = i;
          rd1  = bus0.rsp_rdata;
        end else if (rsp2 == 0) begin
          rsp2 = i;
        end
      end
      if (rsp1 != 0 && acc == 0 && ss0 !== 1'b1) gap_low++;
      if (acc != 0 && i == acc + 1) begin
        bus0.req_valid = 1'b0;
        frame_a = sl_last;
        total++;
        if (ss0 !== 1'b0 || bus0.req_ready !== 1'b0) begin
          bad++;
          $display("FAIL b2b_second_accept: ss_n=%b ready=%b expected 0 0", ss0, bus0.req_ready);
        end
      end
      if (bus0.req_ready === 1'b1) begin
        if (acc == 0) begin
          acc = i;
        end else begin
          done = i;
          break;
        end
      end
    end
    bus0.req_valid = 1'b0;
    total++;
    if (done == 0) begin bad++; $display("FAIL b2b_timeout: second frame did not complete"); end
    total++;
    if (rsp1 != 227 || rd1 !== 32'h0) begin bad++; $display("FAIL b2b_rsp1: at T+%0d rdata=%h expected T+227 0", rsp1, rd1); end
    total++;
    if (acc - rsp1 != CS_GAP || gap_low != 0) begin
      bad++;
      $display("FAIL b2b_gap: ss_n high %0d cycles before accept, low samples=%0d expected %0d 0",
               acc - rsp1, gap_low, CS_GAP);
    end
    total++;
    if (frame_a !== {8'h02, 16'h0020, 32'h01234567}) begin bad++; $display("FAIL b2b_frame_a: got %h", frame_a); end
    total++;
    if (sl_last !== {8'h02, 16'h0024, 32'h89ABCDEF}) begin bad++; $display("FAIL b2b_frame_b: got %h", sl_last); end
    total++;
    if (rsp2 - acc != 227) begin bad++; $display("FAIL b2b_rsp2: at T2+%0d expected T2+227", rsp2 - acc); end
  endtask

  task automatic test_reset_mid_frame();
    int rises = 0, stray = 0;
    int rsp_at, ready_at, rises2, pulses;
    logic [DW-1:0] rdata;
    logic prev_sck;
    sl_rdata = 32'hCAFEF00D;
    bus0.req_valid = 1'b1;
    bus0.req_wr    = 1'b0;
    bus0.req_addr  = 16'h0040;
    prev_sck = sck0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      bus0.req_valid = 1'b0;
      if (sck0 === 1'b1 && prev_sck === 1'b0) rises++;
      prev_sck = sck0;
      if (rises == 20) break;
    end
    rstn = 1'b0;
    #1;
    total++;
    if (rises != 20) begin bad++; $display("FAIL rst_mid_reach: reached %0d SCK edges expected 20", rises); end
    total++;
    if (ss0 !== 1'b1 || sck0 !== 1'b0 || mosi0 !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_pins: ss_n=%b sck=%b mosi=%b expected 1 0 0", ss0, sck0, mosi0);
    end
    total++;
    if (bus0.req_ready !== 1'b1 || bus0.busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_bus: ready=%b busy=%b expected 1 0", bus0.req_ready, bus0.busy);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus0.rsp_valid !== 1'b0 || ss0 !== 1'b1) stray++;
    end
    total++;
    if (stray != 0) begin bad++; $display("FAIL rst_mid_quiet: %0d cycles with rsp_valid or ss_n low, expected 0", stray); end
    sl_rdata = 32'h0BADF00D;
    rstn = 1'b1;
    run_txn(1'b0, 16'h0008, 32'h0, rsp_at, ready_at, rises2, pulses, rdata);
    total++;
    if (rdata !== 32'h0BADF00D || pulses != 1 || rsp_at != 227) begin
      bad++;
      $display("FAIL rst_after_read: rdata=%h pulses=%0d at T+%0d expected 0badf00d 1 T+227",
               rdata, pulses, rsp_at);
    end
    total++;
    if (sl_last[N-1 -: 8] !== 8'h03 || sl_last[DW +: AW] !== 16'h0008) begin
      bad++;
      $display("FAIL rst_after_hdr: got %h expected 030008", sl_last[N-1 -: 24]);
    end
  endtask

  task automatic test_clkdiv5();
    int last_change = 0, bad_half = 0, first_rise = 0, rises = 0, ss_rise = 0, done = 0;
    logic prev_sck, prev_ss;
    bus1.req_valid = 1'b1;
    bus1.req_wr    = 1'b1;
    bus1.req_addr  = 16'h0030;
    bus1.req_wdata = 32'h5A5A5A5A;
    prev_sck = sck1;
    prev_ss  = ss1;
    for (int i = 1; i <= 1200; i++) begin
      @(negedge clk);
      bus1.req_valid = 1'b0;
      if (sck1 !== prev_sck) begin
        if (last_change != 0 && i - last_change != 5) bad_half++;
        if (sck1 === 1'b1) begin
          rises++;
          if (first_rise == 0) first_rise = i;
        end
        last_change = i;
      end
      if (ss1 === 1'b1 && prev_ss === 1'b0 && ss_rise == 0) ss_rise = i;
      prev_sck = sck1;
      prev_ss  = ss1;
      if (i > 1 && bus1.req_ready === 1'b1) begin
        done = i;
        break;
      end
    end
    total++;
    if (done == 0) begin bad++; $display("FAIL div5_timeout: frame did not complete"); end
    total++;
    if (bad_half != 0 || rises != 56) begin
      bad++;
      $display("FAIL div5_halves: %0d wrong half-periods, %0d rises, expected 0 56", bad_half, rises);
    end
    total++;
    if (first_rise != 6) begin bad++; $display("FAIL div5_first_rise: got T+%0d expected T+6", first_rise); end
    total++;
    if (ss_rise != 566) begin bad++; $display("FAIL div5_ss_rise: got T+%0d expected T+566", ss_rise); end
  endtask

  initial begin
    bus0.req_valid = 1'b0;
    bus0.req_wr    = 1'b0;
    bus0.req_addr  = '0;
    bus0.req_wdata = '0;
    bus1.req_valid = 1'b0;
    bus1.req_wr    = 1'b0;
    bus1.req_addr  = '0;
    bus1.req_wdata = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_reset_mid_frame();
    test_clkdiv5();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
